// File: rtl/palindrome_check_arbiter.sv
// Round-robin arbiter sharing one bit-palindrome checker between NREQ requesters.
// Accept -> check -> respond, with a saturating count of palindromic responses.
module palindrome_check_arbiter #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 8,
  parameter int unsigned IDW  = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [NREQ-1:0]    i_req_valid,
  input  logic [NREQ*DW-1:0] i_req_data,
  output logic [NREQ-1:0]    o_req_ready,
  output logic               o_rsp_valid,
  input  logic               i_rsp_ready,
  output logic [IDW-1:0]     o_rsp_id,
  output logic [DW-1:0]      o_rsp_data,
  output logic               o_rsp_is_pal,
  output logic [15:0]        o_pal_count,
  output logic               o_busy
);

  typedef enum logic [1:0] {StIdle, StCheck, StResp} state_e;

  state_e          r_state, w_state_nxt;
  logic [IDW-1:0]  r_prio_ptr, r_id;
  logic [IDW-1:0]  w_idx_hi, w_idx_lo, w_grant_idx, w_ptr_nxt;
  logic            w_hit_hi, w_hit_lo, w_grant_vld;
  logic [NREQ-1:0] w_grant_oh;
  logic [DW-1:0]   r_data, w_grant_data, w_data_rev;
  logic            r_pal, w_is_pal;
  logic [15:0]     r_pal_count;
  logic            w_accept, w_rsp_fire;

  // Two passes fold into one descending loop: the lowest valid index at or above
  // the pointer wins, otherwise wrap to the lowest valid index overall.
  always_comb begin
    w_hit_hi = 1'b0;
    w_hit_lo = 1'b0;
    w_idx_hi = '0;
    w_idx_lo = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (i_req_valid[i]) begin
        w_hit_lo = 1'b1;
        w_idx_lo = IDW'(i);
        if (i >= int'(r_prio_ptr)) begin
          w_hit_hi = 1'b1;
          w_idx_hi = IDW'(i);
        end
      end
    end
    w_grant_vld = w_hit_lo;
    w_grant_idx = w_hit_hi ? w_idx_hi : w_idx_lo;
  end

  always_comb begin
    w_grant_oh   = '0;
    w_grant_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_grant_idx == IDW'(i)) begin
        w_grant_oh[i] = w_grant_vld;
        w_grant_data  = i_req_data[i*DW +: DW];
      end
    end
    w_ptr_nxt = (w_grant_idx == IDW'(NREQ - 1)) ? '0 : w_grant_idx + IDW'(1);
  end

  always_comb begin
    w_data_rev = '0;
    for (int k = 0; k < DW; k++) begin
      w_data_rev[k] = r_data[DW-1-k];
    end
    w_is_pal = (r_data == w_data_rev);
  end

  always_comb begin
    w_state_nxt = r_state;
    o_req_ready = '0;
    w_accept    = 1'b0;
    w_rsp_fire  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_grant_vld) begin
          w_accept    = 1'b1;
          o_req_ready = w_grant_oh;
          w_state_nxt = StCheck;
        end
      end
      StCheck: w_state_nxt = StResp;
      StResp: begin
        if (i_rsp_ready) begin
          w_rsp_fire  = 1'b1;
          w_state_nxt = StIdle;
        end
      end
      default: w_state_nxt = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state     <= StIdle;
      r_prio_ptr  <= '0;
      r_id        <= '0;
      r_data      <= '0;
      r_pal       <= 1'b0;
      r_pal_count <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_data     <= w_grant_data;
        r_id       <= w_grant_idx;
        r_prio_ptr <= w_ptr_nxt;
      end
      if (r_state == StCheck) begin
        r_pal <= w_is_pal;
      end
      if (w_rsp_fire && r_pal && (r_pal_count != 16'hFFFF)) begin
        r_pal_count <= r_pal_count + 16'd1;
      end
    end
  end

  assign o_rsp_valid  = (r_state == StResp);
  assign o_rsp_id     = r_id;
  assign o_rsp_data   = r_data;
  assign o_rsp_is_pal = r_pal;
  assign o_pal_count  = r_pal_count;
  assign o_busy       = (r_state != StIdle);

endmodule

// File: tb/tb_palindrome_check_arbiter.sv
// Directed bench for palindrome_check_arbiter: grants, results, fairness,
// backpressure, mid-operation reset and counter saturation.
module tb_palindrome_check_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [31:0] req_data;
  logic [3:0]  req_ready;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [2:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        rsp_is_pal;
  logic [15:0] pal_count;
  logic        busy;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [15:0] exp_cnt = 16'd0;

  palindrome_check_arbiter #(.NREQ(4), .DW(8), .IDW(3)) dut (
    .i_clk        (clk),
    .i_rst        (rst),
    .i_req_valid  (req_valid),
    .i_req_data   (req_data),
    .o_req_ready  (req_ready),
    .o_rsp_valid  (rsp_valid),
    .i_rsp_ready  (rsp_ready),
    .o_rsp_id     (rsp_id),
    .o_rsp_data   (rsp_data),
    .o_rsp_is_pal (rsp_is_pal),
    .o_pal_count  (pal_count),
    .o_busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    check_eq({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check_eq({tag, "_rsp_id"}, 32'(rsp_id), 32'd0);
    check_eq({tag, "_rsp_data"}, 32'(rsp_data), 32'd0);
    check_eq({tag, "_rsp_is_pal"}, 32'(rsp_is_pal), 32'd0);
    check_eq({tag, "_pal_count"}, 32'(pal_count), 32'd0);
    check_eq({tag, "_busy"}, 32'(busy), 32'd0);
  endtask

  // Single transaction from channel ch, called in IDLE; it is the only valid request.
  task automatic do_txn(input int ch, input logic [7:0] d, input logic exp_pal);
    req_valid[ch]       = 1'b1;
    req_data[ch*8 +: 8] = d;
    #1;
    check_eq("txn_grant", 32'(req_ready), 32'd1 << ch);
    check_eq("txn_idle_busy", 32'(busy), 32'd0);
    step();
    req_valid[ch] = 1'b0;
    #1;
    check_eq("txn_check_busy", 32'(busy), 32'd1);
    check_eq("txn_check_ready", 32'(req_ready), 32'd0);
    check_eq("txn_check_rsp_valid", 32'(rsp_valid), 32'd0);
    step();
    check_eq("txn_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("txn_rsp_id", 32'(rsp_id), 32'(ch));
    check_eq("txn_rsp_data", 32'(rsp_data), 32'(d));
    check_eq("txn_rsp_is_pal", 32'(rsp_is_pal), 32'(exp_pal));
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    if (exp_pal && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
    check_eq("txn_done_rsp_valid", 32'(rsp_valid), 32'd0);
    check_eq("txn_pal_count", 32'(pal_count), 32'(exp_cnt));
  endtask

  logic [7:0] fdat [4] = '{8'h18, 8'h12, 8'hA5, 8'h7E};
  logic       fpal [4] = '{1'b1, 1'b0, 1'b1, 1'b1};

  initial begin
    rst       = 1'b1;
    req_valid = '0;
    req_data  = '0;
    rsp_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    check_reset_outputs("reset");
    check_eq("reset_ready", 32'(req_ready), 32'd0);

    // Single request and assorted patterns
    do_txn(0, 8'h81, 1'b1);
    do_txn(2, 8'h12, 1'b0);
    do_txn(2, 8'h01, 1'b0);
    do_txn(1, 8'h00, 1'b1);
    do_txn(1, 8'hFF, 1'b1);
    do_txn(1, 8'h3C, 1'b1);
    do_txn(1, 8'hA5, 1'b1);
    do_txn(3, 8'h81, 1'b1);  // pointer wraps to 0

    // Fairness with all channels valid and rsp_ready tied high
    req_valid = 4'hF;
    req_data  = {fdat[3], fdat[2], fdat[1], fdat[0]};
    rsp_ready = 1'b1;
    #1;
    for (int g = 0; g < 8; g++) begin
      check_eq("fair_grant", 32'(req_ready), 32'd1 << (g % 4));
      check_eq("fair_count", 32'(pal_count), 32'(exp_cnt));
      step();
      step();
      check_eq("fair_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("fair_rsp_id", 32'(rsp_id), 32'(g % 4));
      check_eq("fair_rsp_data", 32'(rsp_data), 32'(fdat[g % 4]));
      check_eq("fair_rsp_is_pal", 32'(rsp_is_pal), 32'(fpal[g % 4]));
      step();
      if (fpal[g % 4]) exp_cnt = exp_cnt + 16'd1;
    end
    req_valid = '0;
    rsp_ready = 1'b0;
    #1;
    check_eq("fair_final_count", 32'(pal_count), 32'(exp_cnt));

    // Backpressure: response held while another request waits
    req_valid[1]   = 1'b1;
    req_data[15:8] = 8'h5A;
    #1;
    check_eq("bp_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid[1] = 1'b0;
    step();
    req_valid[3]    = 1'b1;
    req_data[31:24] = 8'hC3;
    #1;
    for (int c = 0; c < 5; c++) begin
      check_eq("bp_rsp_valid", 32'(rsp_valid), 32'd1);
      check_eq("bp_rsp_id", 32'(rsp_id), 32'd1);
      check_eq("bp_rsp_data", 32'(rsp_data), 32'h5A);
      check_eq("bp_rsp_is_pal", 32'(rsp_is_pal), 32'd1);
      check_eq("bp_ready_held", 32'(req_ready), 32'd0);
      step();
    end
    rsp_ready = 1'b1;
    #1;
    check_eq("bp_ready_at_release", 32'(req_ready), 32'd0);
    step();
    rsp_ready = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    #1;
    check_eq("bp_count", 32'(pal_count), 32'(exp_cnt));
    check_eq("bp_next_grant", 32'(req_ready), 32'b1000);
    step();
    req_valid[3] = 1'b0;
    step();
    check_eq("bp2_rsp_id", 32'(rsp_id), 32'd3);
    check_eq("bp2_rsp_data", 32'(rsp_data), 32'hC3);
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
    exp_cnt   = exp_cnt + 16'd1;
    check_eq("bp2_count", 32'(pal_count), 32'(exp_cnt));

    // Reset during CHECK
    req_valid[2]    = 1'b1;
    req_data[23:16] = 8'h24;
    #1;
    check_eq("rc_grant", 32'(req_ready), 32'b0100);
    step();
    req_valid[2] = 1'b0;
    check_eq("rc_in_check", 32'(busy), 32'd1);
    rst = 1'b1;
    step();
    rst     = 1'b0;
    exp_cnt = 16'd0;
    #1;
    check_reset_outputs("rst_check");
    req_valid       = 4'b1010;
    req_data[15:8]  = 8'h99;
    req_data[31:24] = 8'hC3;
    #1;
    check_eq("rc_lowest_grant", 32'(req_ready), 32'b0010);
    step();
    req_valid[1] = 1'b0;
    step();
    check_eq("rr_rsp_valid", 32'(rsp_valid), 32'd1);
    check_eq("rr_rsp_data", 32'(rsp_data), 32'h99);

    // Reset during RESP
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check_reset_outputs("rst_resp");
    req_valid[0]  = 1'b1;
    req_data[7:0] = 8'h81;
    #1;
    check_eq("rr_lowest_grant", 32'(req_ready), 32'b0001);
    req_valid[3] = 1'b0;
    do_txn(0, 8'h81, 1'b1);

    // Saturation: preload near the top and run palindromes past it
    force dut.r_pal_count = 16'hFFFE;
    step();
    release dut.r_pal_count;
    exp_cnt = 16'hFFFE;
    #1;
    check_eq("sat_preload", 32'(pal_count), 32'hFFFE);
    do_txn(0, 8'h81, 1'b1);
    check_eq("sat_reach_max", 32'(pal_count), 32'hFFFF);
    do_txn(0, 8'h3C, 1'b1);
    check_eq("sat_hold_max", 32'(pal_count), 32'hFFFF);
    do_txn(0, 8'h12, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/palindrome_check_arbiter.md
# palindrome_check_arbiter

Shares one DW-bit bit-palindrome checker between NREQ requesters. Round-robin arbitration grants one request at a time over a valid/ready handshake. The block registers the check result and returns it with the requester ID over a response handshake, and keeps a saturating count of palindromic results. It sits between the per-channel producers and the single checker datapath.

## Interface
- NREQ, 4: number of requesters, 2..8
- DW, 8: data width checked, in bits
- IDW, 3: width of rsp_id, must satisfy 2^IDW >= NREQ
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous reset, active-high
- req_valid  in  NREQ  per-requester request valid
- req_data  in  NREQ*DW  requester i occupies bits [i*DW +: DW]
- req_ready  out  NREQ  one-hot grant/accept, combinational from state and req_valid
- rsp_valid  out  1  result available
- rsp_ready  in  1  consumer accepts result
- rsp_id  out  IDW  index of the requester that owns the result
- rsp_data  out  DW  data word that was checked
- rsp_is_pal  out  1  1 when rsp_data equals its bit-reversal
- pal_count  out  16  number of accepted responses with rsp_is_pal=1, saturates at 0xFFFF
- busy  out  1  state is not IDLE

## Operation
- Palindrome: is_pal = (d == bitrev(d)), where bitrev(d)[k] = d[DW-1-k]. The check is internal and combinational on the captured data register.
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - If any req_valid is high, choose winner w as the first asserted index at or after prio_ptr, searching upward with wrap-around.
  - Drive req_ready[w]=1; all other req_ready bits are 0.
  - Handshake completes in this cycle. Capture req_data[w] into data_q and w into id_q.
  - Set prio_ptr <= (w+1) mod NREQ, then go to CHECK.
  - If no req_valid is high, req_ready=0, prio_ptr is unchanged, and the FSM stays in IDLE.
- CHECK: register is_pal(data_q) into pal_q, then go to RESP. req_ready is all 0.
- RESP:
  - rsp_valid=1; rsp_id=id_q, rsp_data=data_q, rsp_is_pal=pal_q, all stable while waiting.
  - On rsp_valid & rsp_ready: if pal_q=1 and pal_count != 0xFFFF, increment pal_count; go to IDLE.
  - Otherwise hold indefinitely (backpressure). req_ready stays all 0.
- req_ready is never asserted outside IDLE. A requester must hold req_valid and req_data until it sees its req_ready.
- Reset values: state=IDLE, prio_ptr=0, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_is_pal=0, pal_count=0, busy=0.
- Reset mid-operation: any in-flight request or unaccepted response is discarded. The next cycle behaves as post-reset IDLE with priority at index 0.
- Indices w >= NREQ never occur. Unused high rsp_id bits are 0.

## Timing
- Request accepted in cycle T (IDLE, handshake).
- CHECK in T+1.
- rsp_valid high from T+2.
- With rsp_ready=1 at T+2, the FSM returns to IDLE at T+3, so the next accept can happen at T+3.
- Maximum throughput: 1 request per 3 cycles. Fixed latency is 2 cycles from accept to rsp_valid.
- pal_count updates on the clock edge ending the response handshake cycle, so the new value is visible at T+3.
- busy=1 in CHECK and RESP.
- Simultaneous requests from all NREQ channels held continuously are granted in rotating order: prio_ptr, prio_ptr+1, and so on. No channel waits more than NREQ grants.
- Requests arriving while busy are not accepted. They are arbitrated on the first IDLE cycle using the prio_ptr value at that point.

## Test plan
- Single request: req 0 sends 0x81 -> req_ready[0] in the accept cycle; rsp_valid 2 cycles later with id=0, data=0x81, is_pal=1; pal_count goes 0 -> 1.
- Non-palindromes: req 2 sends 0x12, then 0x01 -> both responses have is_pal=0 and pal_count is unchanged. Also 0x00, 0xFF, 0x3C, 0xA5 -> is_pal=1 each.
- Fairness: all 4 valid continuously with 0x18, 0x12, 0xA5, 0x7E -> grant order 0,1,2,3,0,…; each response id matches its data; responses accepted every 3 cycles with rsp_ready tied high.
- Backpressure: hold rsp_ready=0 for 5 cycles -> rsp_valid, rsp_id, rsp_data and rsp_is_pal are stable; req_ready stays 0 even with req_valid high; the accept happens the cycle after rsp_ready rises.
- Reset mid-op: assert rst during CHECK and during RESP -> the next cycle shows all outputs at reset values, and the next grant goes to the lowest valid index.
- Saturation: force 65537 palindromic responses, or preload via a long run -> pal_count holds at 0xFFFF.
